// File: rtl/mac_array_engine_pkg.sv
// Shared types, derived sizes and arithmetic helpers for the multi-lane MAC engine.
// The optional scaling stage is selected with MAC_SCALE_EN in the lane and top files.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } mac_state_e;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  localparam int MAC_WIDTH    = 8;
  localparam int MAC_D_K_MAX  = 64;
  localparam int MAC_OUT_FRAC = 7;

  function automatic int calc_prod_shift(input int width, input int out_frac);
    return 2 * (width - 1) - out_frac;
  endfunction

  function automatic int calc_acc_width(input int width, input int d_k_max);
    return 2 * width + $clog2(d_k_max) + 1;
  endfunction

  function automatic int calc_cnt_width(input int d_k_max);
    return $clog2(d_k_max) + 1;
  endfunction

  localparam int PROD_SHIFT = calc_prod_shift(MAC_WIDTH, MAC_OUT_FRAC);
  localparam int ACC_WIDTH  = calc_acc_width(MAC_WIDTH, MAC_D_K_MAX);
  localparam int CNT_WIDTH  = calc_cnt_width(MAC_D_K_MAX);

  // Right shift with round-half-away-from-zero; a non-positive shift is a plain left shift.
  function automatic logic signed [63:0] round_shift_afz(input logic signed [63:0] v,
                                                        input int sh);
    logic [63:0] mag;
    logic [63:0] r;
    if (sh <= 0) return v <<< (-sh);
    mag = v[63] ? 64'(-v) : 64'(v);
    r   = (mag + (64'd1 << (sh - 1))) >> sh;
    return v[63] ? $signed(-r) : $signed(r);
  endfunction

  function automatic sat_res_t sat_to_width(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           res;
    hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (w - 1));
    res.sat = 1'b0;
    res.val = v;
    if (v > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (v < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_array_engine_lane.sv
// One dot-product lane: rounded product, accumulator, optional scale (MAC_SCALE_EN) and
// saturating output register. Strobes come from the engine FSM.
module mac_lane
  import mac_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int D_K_MAX     = 64,
  parameter int OUT_FRAC    = 7,
  parameter int OUT_WIDTH   = 16,
  parameter int SCALE_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic                 acc_i,
  input  logic                 fin_i,
  input  logic [WIDTH-1:0]     q_i,
  input  logic [WIDTH-1:0]     k_i,
  output logic [OUT_WIDTH-1:0] z_o,
  output logic                 sat_o
);

  localparam int P_SHIFT = calc_prod_shift(WIDTH, OUT_FRAC);
  localparam int ACC_W   = calc_acc_width(WIDTH, D_K_MAX);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [63:0]        prod_r;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [63:0]        fin_v;
  sat_res_t                  fin_res;
  logic [OUT_WIDTH-1:0]      z_q;
  logic                      sat_q;
  logic                      unused_bits;

  assign prod   = $signed(q_i) * $signed(k_i);
  assign prod_r = round_shift_afz(64'(prod), P_SHIFT);

  // Finalisation sees acc_d so the last beat's product is included in the same cycle.
  always_comb begin
    acc_d = acc_q;
    if (clr_i)       acc_d = '0;
    else if (load_i) acc_d = ACC_W'(prod_r);
    else if (acc_i)  acc_d = acc_q + ACC_W'(prod_r);
  end

`ifdef MAC_SCALE_EN
  assign fin_v = round_shift_afz(64'(acc_d), SCALE_SHIFT);
`else
  assign fin_v = 64'(acc_d);
`endif

  assign fin_res     = sat_to_width(fin_v, OUT_WIDTH);
  assign unused_bits = ^{fin_res.val, prod_r, SCALE_SHIFT};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      z_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (fin_i) begin
        z_q   <= fin_res.val[OUT_WIDTH-1:0];
        sat_q <= fin_res.sat;
      end
    end
  end

  assign z_o   = z_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/mac_array_engine.sv
// N_LANES parallel QK^T dot products with valid/ready streaming in and out.
// Define MAC_SCALE_EN to compile in the 1/sqrt(d_k) right-shift before saturation.
module mac_array_engine
  import mac_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int N_LANES     = 4,
  parameter int D_K_MAX     = 64,
  parameter int OUT_FRAC    = 7,
  parameter int OUT_WIDTH   = 16,
  parameter int SCALE_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(D_K_MAX):0]     len,
  output logic                         busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             q_in,
  input  logic [N_LANES*WIDTH-1:0]     k_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_LANES*OUT_WIDTH-1:0] z_out,
  output logic [N_LANES-1:0]           sat_flag,
  output logic [1:0]                   dbg_state
);

  localparam int         CNT_W   = calc_cnt_width(D_K_MAX);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ACCUM = ACCUM;
  localparam logic [1:0] S_OUT   = OUT;

  // Handshakes: a beat moves on a cycle with in_valid && in_ready; a result moves on a
  // cycle with out_valid && out_ready. Neither valid may depend on the matching ready.
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             start_ok, beat, last, clr, load, acc, fin;

  assign start_ok = start && (state_q == S_IDLE);
  assign beat     = in_valid && (state_q == S_ACCUM);
  assign last     = beat && (cnt_q == len_q - CNT_W'(1));
  assign clr      = start_ok && (len == '0);
  assign load     = beat && (cnt_q == '0);
  assign acc      = beat && (cnt_q != '0);
  assign fin      = last || clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          state_d = (len == '0) ? S_OUT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUT);
  assign dbg_state = state_q;

  for (genvar j = 0; j < N_LANES; j++) begin : g_lane
    mac_lane #(
      .WIDTH      (WIDTH),
      .D_K_MAX    (D_K_MAX),
      .OUT_FRAC   (OUT_FRAC),
      .OUT_WIDTH  (OUT_WIDTH),
      .SCALE_SHIFT(SCALE_SHIFT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .load_i(load),
      .acc_i (acc),
      .fin_i (fin),
      .q_i   (q_in),
      .k_i   (k_in[j*WIDTH +: WIDTH]),
      .z_o   (z_out[j*OUT_WIDTH +: OUT_WIDTH]),
      .sat_o (sat_flag[j])
    );
  end

endmodule

// File: tb/tb_mac_array_engine.sv
// Directed bench for mac_array_engine: arithmetic model plus result scoreboard and pins.
module tb_mac_array_engine;

  localparam int W  = 8;
  localparam int NL = 4;
  localparam int DK = 64;
  localparam int OF = 7;
  localparam int OW = 12;
  localparam int SS = 3;
  localparam int LW = $clog2(DK) + 1;
  localparam int RW = NL * OW + NL;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, out_ready;
  logic              busy, in_ready, out_valid;
  logic [LW-1:0]     len;
  logic [W-1:0]      q_in;
  logic [NL*W-1:0]   k_in;
  logic [NL*OW-1:0]  z_out;
  logic [NL-1:0]     sat_flag;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];
  int m_sum[NL];
  int m_len;
  int m_cnt;
  bit m_active = 1'b0;

  always #5 clk = ~clk;

  mac_array_engine #(
    .WIDTH(W), .N_LANES(NL), .D_K_MAX(DK), .OUT_FRAC(OF), .OUT_WIDTH(OW), .SCALE_SHIFT(SS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .q_in(q_in), .k_in(k_in),
    .out_valid(out_valid), .out_ready(out_ready), .z_out(z_out), .sat_flag(sat_flag),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int rnd_afz(input int v, input int sh);
    int d = 1 << sh;
    if (v >= 0) return (v + d / 2) / d;
    return -((-v + d / 2) / d);
  endfunction

  function automatic longint zl(input int j);
    return longint'($signed(z_out[j*OW +: OW]));
  endfunction

  function automatic logic [NL*W-1:0] kv(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [RW-1:0] model_result();
    logic [RW-1:0] r = '0;
    int v;
    for (int j = 0; j < NL; j++) begin
      v = m_sum[j];
`ifdef MAC_SCALE_EN
      v = rnd_afz(v, SS);
`endif
      if (v > (1 << (OW - 1)) - 1) begin
        v = (1 << (OW - 1)) - 1;
        r[NL*OW + j] = 1'b1;
      end else if (v < -(1 << (OW - 1))) begin
        v = -(1 << (OW - 1));
        r[NL*OW + j] = 1'b1;
      end
      r[j*OW +: OW] = OW'(v);
    end
    return r;
  endfunction

  task automatic model_start(input int l);
    m_len = l;
    m_cnt = 0;
    m_active = 1'b1;
    for (int j = 0; j < NL; j++) m_sum[j] = 0;
    if (l == 0) begin
      exp_q.push_back(model_result());
      m_active = 1'b0;
    end
  endtask

  task automatic model_beat(input logic [W-1:0] q, input logic [NL*W-1:0] k);
    int p;
    if (!m_active) return;
    for (int j = 0; j < NL; j++) begin
      p = int'($signed(q)) * int'($signed(k[j*W +: W]));
      m_sum[j] += rnd_afz(p, 2 * (W - 1) - OF);
    end
    m_cnt++;
    if (m_cnt == m_len) begin
      exp_q.push_back(model_result());
      m_active = 1'b0;
    end
  endtask

  // Compare process: scoreboard on every result handshake, hold and status checks each cycle.
  logic [NL*OW-1:0] prev_z;
  logic [NL-1:0]    prev_sat;
  logic             prev_ov = 1'b0;
  always @(negedge clk) begin
    logic [RW-1:0] e;
    #1;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      check("busy_rel", busy, in_ready | out_valid);
      if (prev_ov && out_valid) begin
        check("hold_z", z_out, prev_z);
        check("hold_sat", sat_flag, prev_sat);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("res_z", z_out, e[NL*OW-1:0]);
          check("res_sat", sat_flag, e[RW-1:NL*OW]);
        end
      end
      prev_ov  = out_valid;
      prev_z   = z_out;
      prev_sat = sat_flag;
    end
  end

  task automatic job_start(input int l);
    start = 1'b1;
    len   = LW'(l);
    model_start(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] q, input logic [NL*W-1:0] k, input int gap);
    int waitc = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    q_in = q;
    k_in = k;
    in_valid = 1'b1;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_wait", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    model_beat(q, k);
  endtask

  task automatic collect(input int stall);
    int waitc = 0;
    while (!out_valid && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("ov_wait", out_valid, 1'b1);
    for (int i = 0; i < stall; i++) begin
      start = 1'b1;
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_ov", out_valid, 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("post_ov", out_valid, 1'b0);
    check("post_busy", busy, 1'b0);
  endtask

  task automatic pin(input string name, input int l0, l1, l2, l3, input logic [NL-1:0] s);
    int lit[NL];
    lit = '{l0, l1, l2, l3};
    for (int j = 0; j < NL; j++) check(name, zl(j), longint'(lit[j]));
    check({name, "_sat"}, sat_flag, s);
  endtask

  logic [7:0] qt[8] = '{8'h12, 8'hF3, 8'h7F, 8'h80, 8'h01, 8'hA5, 8'h3C, 8'hE0};

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = '0; q_in = '0; k_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_z", z_out, '0);
    check("rst_sat", sat_flag, '0);

    // All lanes 0.5*0.5 over four beats.
    job_start(4);
    for (int i = 0; i < 4; i++) begin
      beat(8'h40, kv(8'h40, 8'h40, 8'h40, 8'h40), 0);
      if (i < 3) check("s1_mid_ov", out_valid, 1'b0);
    end
    check("s1_latency", out_valid, 1'b1);
`ifdef MAC_SCALE_EN
    pin("s1", 16, 16, 16, 16, 4'b0000);
`else
    pin("s1", 128, 128, 128, 128, 4'b0000);
`endif
    collect(0);

    // Negative lane 1.
    job_start(4);
    for (int i = 0; i < 4; i++) beat(8'h40, kv(8'h40, 8'hC0, 8'h40, 8'h40), 0);
`ifdef MAC_SCALE_EN
    pin("s2", 16, -16, 16, 16, 4'b0000);
`else
    pin("s2", 128, -128, 128, 128, 4'b0000);
`endif
    collect(0);

    // Full-length job at extreme values, both saturation directions.
    job_start(64);
    for (int i = 0; i < 64; i++) beat(8'h7F, kv(8'h7F, 8'h7F, 8'h81, 8'h81), 0);
`ifdef MAC_SCALE_EN
    pin("s3", 1008, 1008, -1008, -1008, 4'b0000);
`else
    pin("s3", 2047, 2047, -2048, -2048, 4'b1111);
`endif
    collect(0);

    // Gated beats with random gaps, then a long output stall with start held.
    job_start(8);
    for (int i = 0; i < 8; i++) begin
      beat(qt[i], kv(qt[7-i], ~qt[i], 8'h55, 8'h80), $urandom_range(0, 2));
      if (i < 7) check("s4_mid_ov", out_valid, 1'b0);
    end
    check("s4_latency", out_valid, 1'b1);
    collect(5);

    // Zero-length job.
    job_start(0);
    check("len0_ov", out_valid, 1'b1);
    pin("len0", 0, 0, 0, 0, 4'b0000);
    collect(0);

    // Single beat exercising the half-LSB rounding of products.
    job_start(1);
    beat(8'h01, kv(8'h40, 8'hC0, 8'h01, 8'h00), 0);
`ifdef MAC_SCALE_EN
    pin("round1", 0, 0, 0, 0, 4'b0000);
`else
    pin("round1", 1, -1, 0, 0, 4'b0000);
`endif
    collect(0);

    // Abort mid-job with reset, then a fresh short job.
    job_start(8);
    for (int i = 0; i < 3; i++) beat(8'h40, kv(8'h40, 8'h40, 8'h40, 8'h40), 0);
    rst = 1'b1;
    m_active = 1'b0;
    @(negedge clk);
    check("abort_ov", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    rst = 1'b0;
    job_start(2);
    for (int i = 0; i < 2; i++) beat(8'h40, kv(8'h40, 8'h40, 8'h40, 8'h40), 1);
`ifdef MAC_SCALE_EN
    pin("fresh", 8, 8, 8, 8, 4'b0000);
`else
    pin("fresh", 64, 64, 64, 64, 4'b0000);
`endif
    collect(0);

    // +/-132 accumulated: scale boundary where x.5 rounds away from zero.
    job_start(5);
    for (int i = 0; i < 4; i++) beat(8'h40, kv(8'h40, 8'h40, 8'hC0, 8'hC0), 0);
    beat(8'h40, kv(8'h08, 8'h08, 8'hF8, 8'hF8), 0);
`ifdef MAC_SCALE_EN
    pin("s132", 17, 17, -17, -17, 4'b0000);
`else
    pin("s132", 132, 132, -132, -132, 4'b0000);
`endif
    collect(2);

    repeat (2) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_array_engine.md
Name: mac_array_engine

Overview:
Multi-lane successor to the single-lane QKT MAC engine. Computes N_LANES dot products z[j] = Σ q[k]·k_j[k] in parallel, one shared q element per beat, over a runtime length LEN (1..D_K_MAX). Inputs and outputs use valid/ready handshakes, outputs are saturated, and an optional 1/sqrt(d_k) scaling stage can be compiled in. Sits between the Q/K SRAM streamers and the softmax stage.

Parameters:
WIDTH, 8, signed input element width (Q0.(WIDTH-1))
N_LANES, 4, parallel k_j lanes / outputs
D_K_MAX, 64, maximum vector length
OUT_FRAC, 7, fractional bits of product and output (Q.OUT_FRAC)
OUT_WIDTH, 16, signed output width per lane, saturated
SCALE_SHIFT, 3, right shift applied when MAC_SCALE_EN is defined

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse: begin job (accepted only in IDLE)
len  in  $clog2(D_K_MAX)+1  beats per job, sampled on accepted start
busy  out  1  high outside IDLE
in_valid  in  1  q/k beat valid
in_ready  out  1  engine accepts beat (high only in ACCUM)
q_in  in  WIDTH  shared q element
k_in  in  N_LANES*WIDTH  lane j at [j*WIDTH +: WIDTH]
out_valid  out  1  results valid
out_ready  in  1  downstream accepts results
z_out  out  N_LANES*OUT_WIDTH  lane j at [j*OUT_WIDTH +: OUT_WIDTH]
sat_flag  out  N_LANES  lane j saturated in this result

Behaviour:
- Single clock; reset is synchronous and active-high. Reset: state=IDLE, counter=0, accumulators=0, busy=0, in_ready=0, out_valid=0, z_out=0, sat_flag=0. Reset mid-job aborts it; no partial result is emitted.
- FSM IDLE→ACCUM on start. len==0 goes directly IDLE→OUT with z_out=0 and sat_flag=0. start outside IDLE is ignored.
- ACCUM: in_ready=1. Beat accepted when in_valid&&in_ready. The first beat loads the accumulator; later beats add. The counter increments per accepted beat. The beat with counter==len-1 moves to OUT. No beat is accepted when in_valid=0, and the counter holds.
- Product: p = q_in*k_j, full 2*WIDTH signed, Q1.(2*WIDTH-2). Rounding is half away from zero: r = sign(p)·((|p| + 2^(S-1)) >> S), where S = 2*(WIDTH-1)-OUT_FRAC. S≤0 means a left shift with no rounding.
- Accumulator width = 2*WIDTH + $clog2(D_K_MAX) + 1. It never overflows internally.
- Finalisation is registered on the transition into OUT. Optional scale is applied, then the value saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. sat_flag[j]=1 if clipped.
- Latency: out_valid rises the cycle after the last beat is accepted (len==0: the cycle after start).
- OUT: out_valid=1. z_out and sat_flag are held stable until out_valid&&out_ready, then the FSM goes to IDLE and out_valid drops next cycle. A start in that same handshake cycle is ignored; the next job needs start in IDLE.
- busy = (state != IDLE).

Optional Feature:
MAC_SCALE_EN defined:
- Before saturation, each accumulator becomes round-half-away-from-zero(acc >> SCALE_SHIFT). This is the 1/sqrt(d_k) scale.
- Intended: SCALE_SHIFT = log2(sqrt(D_K_MAX)).

MAC_SCALE_EN undefined:
- No scaling logic; the raw accumulator is saturated.
- SCALE_SHIFT is unused.

Decomposition:
- Package mac_pkg: state enum (IDLE, ACCUM, OUT); functions round_shift_afz (signed, shift) and sat_to_width; derived localparams PROD_SHIFT, ACC_WIDTH, CNT_WIDTH.
- Sub-module mac_lane: per-lane product, rounding, accumulator, finalise/saturate. Controlled by load/acc/finalise strobes from the top FSM. Instantiated N_LANES times via generate.

Test Plan:
- Defaults, len=4, every beat q=0x40, all k=0x40 → per-product 32; one cycle after 4th beat out_valid=1, all z=128 (0x0080), sat_flag=0.
- Lane 1 k=0xC0, others 0x40, q=0x40, len=4 → z[1]=-128 (each product -32, not -33), others 128.
- OUT_WIDTH=12, q=k=0x7F, len=64 → product 126, sum 8064, z=2047, sat_flag=all 1. Negative case (k=0x81) → z=-2048, sat_flag=1.
- in_valid toggled 1/0 randomly, len=8 → counter advances only on accepted beats; result equals ungated sum. Hold out_ready=0 for 5 cycles → z_out stable, in_ready=0, start ignored.
- len=0 start → out_valid next cycle with z=0. Assert rst after 3 beats of len=8 → next cycle out_valid=0, busy=0; new job len=2 returns a fresh (not accumulated) result.
- With MAC_SCALE_EN, SCALE_SHIFT=3, scenario 1 → z=16. Value 132 → 17 (16.5 rounds up). Value -132 → -17.
